// File: rtl/bcd_cascade_disp_if.sv
// Bus between the decade counter side (master) and bcd_cascade_disp (slave).
// It carries the counter sample inputs and the cascade/display outputs.
interface bcd_cascade_disp_if #(
    parameter int N_HI = 2
);
    logic                dir;
    logic                cnt_clr;
    logic [3:0]          cntQ;
    logic [4*N_HI-1:0]   hi_bcd;
    logic                carry;
    logic                borrow;
    logic                ovf;
    logic [N_HI:0]       an;
    logic [6:0]          seg;

    modport master (
        output dir, cnt_clr, cntQ,
        input  hi_bcd, carry, borrow, ovf, an, seg
    );

    modport slave (
        input  dir, cnt_clr, cntQ,
        output hi_bcd, carry, borrow, ovf, an, seg
    );
endinterface

// File: rtl/bcd_cascade_disp.sv
// Extends a single-digit decade counter with N_HI higher BCD digits and scans all
// digits onto one 7-segment bus. Define LZB_EN for leading-zero blanking.
module bcd_cascade_disp #(
    parameter int N_HI     = 2,
    parameter int SCAN_DIV = 4
) (
    input logic               clk,
    input logic               reset,
    bcd_cascade_disp_if.slave bus
);
    localparam int HW    = 4 * N_HI;
    localparam int NA    = N_HI + 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_HI > 0) ? $clog2(N_HI + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_HI);

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

`ifdef LZB_EN
    // Digit k is a leading zero when it and every digit above it are zero.
    function automatic logic lead_zero(input logic [HW-1:0] h, input int k);
        logic z;
        z = 1'b1;
        for (int j = 0; j < N_HI; j++) begin
            z = ((j >= k) && (h[4*j +: 4] != 4'd0)) ? 1'b0 : z;
        end
        return z;
    endfunction
`endif

    logic [3:0]       prev_q_r;
    logic             prev_vld_r;
    logic [HW-1:0]    hi_r;
    logic             carry_r;
    logic             borrow_r;
    logic             ovf_r;
    logic [DIV_W-1:0] div_r;
    logic [IDX_W-1:0] idx_r;
    logic [NA-1:0]    an_r;
    logic [6:0]       seg_r;

    logic             wrap_ok_s;
    logic             up_wrap_s;
    logic             dn_wrap_s;
    logic [HW-1:0]    hi_nxt_s;
    logic             rip_s;
    logic             top_wrap_s;
    logic [3:0]       dig_s;
    logic [3:0]       sel_dig_s;
    logic             blank_s;
    logic [6:0]       seg_nxt_s;

    // The current dir wins even if it toggles on the wrap edge.
    assign wrap_ok_s = prev_vld_r & ~bus.cnt_clr;
    assign up_wrap_s = wrap_ok_s & ~bus.dir & (prev_q_r == 4'd9) & (bus.cntQ == 4'd0);
    assign dn_wrap_s = wrap_ok_s &  bus.dir & (prev_q_r == 4'd0) & (bus.cntQ == 4'd9);

    // Ripple carry/borrow through all higher digits within one cycle.
    always_comb begin
        hi_nxt_s = hi_r;
        rip_s    = up_wrap_s | dn_wrap_s;
        dig_s    = 4'd0;
        for (int k = 0; k < N_HI; k++) begin
            dig_s = hi_r[4*k +: 4];
            if (!rip_s) begin
                hi_nxt_s[4*k +: 4] = dig_s;
            end else if (up_wrap_s) begin
                if (dig_s >= 4'd9) begin
                    hi_nxt_s[4*k +: 4] = 4'd0;
                end else begin
                    hi_nxt_s[4*k +: 4] = dig_s + 4'd1;
                    rip_s              = 1'b0;
                end
            end else begin
                if (dig_s == 4'd0) begin
                    hi_nxt_s[4*k +: 4] = 4'd9;
                end else begin
                    hi_nxt_s[4*k +: 4] = dig_s - 4'd1;
                    rip_s              = 1'b0;
                end
            end
        end
        top_wrap_s = rip_s;
    end

    // Pick the digit under the scan index; index 0 is the live counter digit.
    always_comb begin
        sel_dig_s = bus.cntQ;
        blank_s   = 1'b0;
        for (int k = 0; k < N_HI; k++) begin
            sel_dig_s = (idx_r == IDX_W'(k + 1)) ? hi_r[4*k +: 4] : sel_dig_s;
`ifdef LZB_EN
            blank_s   = (idx_r == IDX_W'(k + 1)) ? lead_zero(hi_r, k) : blank_s;
`else
            blank_s   = 1'b0;
`endif
        end
        seg_nxt_s = blank_s ? 7'h00 : seg_decode(sel_dig_s);
    end

    // Counter sampling, cascade digits and wrap pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q_r   <= 4'd0;
            prev_vld_r <= 1'b0;
            hi_r       <= '0;
            carry_r    <= 1'b0;
            borrow_r   <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            prev_q_r   <= bus.cntQ;
            prev_vld_r <= ~bus.cnt_clr;
            hi_r       <= hi_nxt_s;
            carry_r    <= up_wrap_s;
            borrow_r   <= dn_wrap_s;
            ovf_r      <= top_wrap_s;
        end
    end

    // Scan divider, digit index and registered display drive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_r <= '0;
            idx_r <= '0;
            an_r  <= NA'(1);
            seg_r <= 7'h00;
        end else begin
            an_r  <= NA'(1) << idx_r;
            seg_r <= seg_nxt_s;
            if (div_r == DIV_LAST) begin
                div_r <= '0;
                idx_r <= (idx_r == IDX_LAST) ? IDX_W'(0) : idx_r + IDX_W'(1);
            end else begin
                div_r <= div_r + DIV_W'(1);
                idx_r <= idx_r;
            end
        end
    end

    assign bus.hi_bcd = hi_r;
    assign bus.carry  = carry_r;
    assign bus.borrow = borrow_r;
    assign bus.ovf    = ovf_r;
    assign bus.an     = an_r;
    assign bus.seg    = seg_r;
endmodule

// File: tb/tb_bcd_cascade_disp.sv
// Scoreboard bench for bcd_cascade_disp (N_HI=2, SCAN_DIV=4): the driver queues the
// expected post-edge outputs for each cycle, a monitor pops and compares them.
module tb_bcd_cascade_disp;
    logic clk = 1'b0;
    logic reset = 1'b0;

    bcd_cascade_disp_if #(.N_HI(2)) bus ();

    bcd_cascade_disp #(.N_HI(2), .SCAN_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         ck_hi;
        logic [7:0] hi;
        bit         ck_fl;
        logic [2:0] fl;   // {carry, borrow, ovf}
        bit         ck_an;
        logic [2:0] an;
        bit         ck_seg;
        logic [6:0] seg;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [2:0] an_tab [3] = '{3'b001, 3'b010, 3'b100};
    logic [6:0] seg_a  [3] = '{7'h07, 7'h06, 7'h5B};
`ifdef LZB_EN
    logic [6:0] seg_b0 [3] = '{7'h4F, 7'h00, 7'h00};
    logic [6:0] seg_b5 [3] = '{7'h4F, 7'h6D, 7'h00};
`else
    logic [6:0] seg_b0 [3] = '{7'h4F, 7'h3F, 7'h3F};
    logic [6:0] seg_b5 [3] = '{7'h4F, 7'h6D, 7'h3F};
`endif

    function automatic exp_t ex_none();
        exp_t e;
        e.name = "none"; e.ck_hi = 1'b0; e.hi = 8'h00; e.ck_fl = 1'b0; e.fl = 3'b000;
        e.ck_an = 1'b0; e.an = 3'b000; e.ck_seg = 1'b0; e.seg = 7'h00;
        return e;
    endfunction

    function automatic exp_t ex_fl(input string n, input logic [7:0] h, input logic [2:0] f);
        exp_t e;
        e = ex_none();
        e.name = n; e.ck_hi = 1'b1; e.hi = h; e.ck_fl = 1'b1; e.fl = f;
        return e;
    endfunction

    function automatic exp_t ex_sc(input string n, input logic [2:0] a, input logic [6:0] s);
        exp_t e;
        e = ex_none();
        e.name = n; e.ck_an = 1'b1; e.an = a; e.ck_seg = 1'b1; e.seg = s;
        return e;
    endfunction

    function automatic exp_t ex_rst(input string n);
        exp_t e;
        e = ex_fl(n, 8'h00, 3'b000);
        e.ck_an = 1'b1; e.an = 3'b001; e.ck_seg = 1'b1; e.seg = 7'h00;
        return e;
    endfunction

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", n, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic step(input logic r, input logic d, input logic c, input logic [3:0] q, input exp_t e);
        @(negedge clk);
        reset       = r;
        bus.dir     = d;
        bus.cnt_clr = c;
        bus.cntQ    = q;
        sb.push_back(e);
    endtask

    // Monitor: one expectation per rising edge, checked just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.ck_hi)  chk({e.name, ".hi"},  bus.hi_bcd, e.hi);
                if (e.ck_fl)  chk({e.name, ".cbo"}, {5'd0, bus.carry, bus.borrow, bus.ovf}, {5'd0, e.fl});
                if (e.ck_an)  chk({e.name, ".an"},  {5'd0, bus.an}, {5'd0, e.an});
                if (e.ck_seg) chk({e.name, ".seg"}, {1'b0, bus.seg}, {1'b0, e.seg});
            end
        end
    end

    initial begin
        bus.dir = 1'b0; bus.cnt_clr = 1'b0; bus.cntQ = 4'd0;

        // Reset and basic carry / borrow / overflow
        step(1'b0, 1'b0, 1'b0, 4'd0, ex_rst("rst0"));
        step(1'b0, 1'b0, 1'b0, 4'd0, ex_rst("rst1"));
        step(1'b1, 1'b0, 1'b0, 4'd8, ex_fl("rel", 8'h00, 3'b000));
        step(1'b1, 1'b0, 1'b0, 4'd9, ex_fl("up_pre", 8'h00, 3'b000));
        step(1'b1, 1'b0, 1'b0, 4'd0, ex_fl("up_wrap", 8'h01, 3'b100));
        step(1'b1, 1'b0, 1'b0, 4'd0, ex_fl("up_after", 8'h01, 3'b000));
        step(1'b1, 1'b1, 1'b0, 4'd9, ex_fl("dn_wrap", 8'h00, 3'b010));
        step(1'b1, 1'b1, 1'b0, 4'd9, ex_fl("dn_hold", 8'h00, 3'b000));
        step(1'b1, 1'b1, 1'b0, 4'd0, ex_fl("dn_9to0", 8'h00, 3'b000));
        step(1'b1, 1'b1, 1'b0, 4'd9, ex_fl("dn_ovf", 8'h99, 3'b011));
        step(1'b1, 1'b0, 1'b0, 4'd9, ex_fl("hold99", 8'h99, 3'b000));
        step(1'b1, 1'b0, 1'b0, 4'd0, ex_fl("up_ovf", 8'h00, 3'b101));
        step(1'b1, 1'b0, 1'b0, 4'd9, ex_fl("up_0to9", 8'h00, 3'b000));
        step(1'b1, 1'b1, 1'b0, 4'd0, ex_fl("dir_flip", 8'h00, 3'b000));
        // Invalid codes never wrap
        step(1'b1, 1'b0, 1'b0, 4'd9, ex_none());
        step(1'b1, 1'b0, 1'b0, 4'd12, ex_fl("bad_9_12", 8'h00, 3'b000));
        step(1'b1, 1'b0, 1'b0, 4'd0, ex_fl("bad_12_0", 8'h00, 3'b000));
        step(1'b1, 1'b1, 1'b0, 4'd15, ex_none());
        step(1'b1, 1'b1, 1'b0, 4'd9, ex_fl("bad_15_9", 8'h00, 3'b000));
        // cnt_clr suppression, including the first sample after it
        step(1'b1, 1'b0, 1'b0, 4'd9, ex_fl("clr_pre", 8'h00, 3'b000));
        step(1'b1, 1'b0, 1'b1, 4'd0, ex_fl("clr_block", 8'h00, 3'b000));
        step(1'b1, 1'b0, 1'b0, 4'd1, ex_none());
        step(1'b1, 1'b0, 1'b0, 4'd9, ex_none());
        step(1'b1, 1'b0, 1'b0, 4'd0, ex_fl("clr_after", 8'h01, 3'b100));
        step(1'b1, 1'b0, 1'b1, 4'd9, ex_fl("vld_pre", 8'h01, 3'b000));
        step(1'b1, 1'b0, 1'b0, 4'd0, ex_fl("vld_block", 8'h01, 3'b000));
        step(1'b1, 1'b0, 1'b0, 4'd9, ex_none());
        step(1'b1, 1'b0, 1'b0, 4'd0, ex_fl("vld_ok", 8'h02, 3'b100));
        // Reset over a pending wrap; prev state must be cleared too
        step(1'b1, 1'b0, 1'b0, 4'd9, ex_fl("mid_pre", 8'h02, 3'b000));
        step(1'b0, 1'b0, 1'b0, 4'd0, ex_rst("mid_rst0"));
        step(1'b0, 1'b0, 1'b0, 4'd0, ex_rst("mid_rst1"));
        step(1'b1, 1'b1, 1'b0, 4'd9, ex_fl("post_rst", 8'h00, 3'b000));

        // Scan with hundreds=2, tens=1, live digit 7
        step(1'b0, 1'b0, 1'b0, 4'd0, ex_rst("a_rst0"));
        step(1'b0, 1'b0, 1'b0, 4'd0, ex_rst("a_rst1"));
        for (int i = 0; i < 21; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd9, ex_none());
            step(1'b1, 1'b0, 1'b0, 4'd0, (i == 20) ? ex_fl("casc21", 8'h21, 3'b100) : ex_none());
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 4'd7, ex_none());
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 4'd7, ex_sc("scan_a", an_tab[i/4], seg_a[i/4]));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'd12, ex_sc("dash", 3'b001, 7'h40));

        // Leading zeros: hi=00, then hi=05
        step(1'b0, 1'b0, 1'b0, 4'd0, ex_rst("b_rst0"));
        step(1'b0, 1'b0, 1'b0, 4'd0, ex_rst("b_rst1"));
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 4'd3, ex_sc("scan_00", an_tab[i/4], seg_b0[i/4]));
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd9, ex_none());
            step(1'b1, 1'b0, 1'b0, 4'd0, (i == 4) ? ex_fl("casc05", 8'h05, 3'b100) : ex_none());
        end
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 4'd3, ex_none());
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 4'd3, ex_sc("scan_05", an_tab[i/4], seg_b5[i/4]));

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
